sync_tgl_rcv: RTL and testbench
===============================

// Module: sync_tgl_rcv
// PURPOSE
//  Receive end of the toggle-encoded event crossing, in the clkb domain. Samples an asynchronous
//  toggle from the sending domain and turns each edge into one event pulse. Queues events as a
//  saturating pending count with a valid/ready drain and a sticky overflow flag.
//  Optionally returns an ack toggle so the sender can throttle outstanding events.
// PARAMETERS
//  RESET_VAL   1'b0  reset value of synchronizer flops, edge reference and ack_t
//  SYNC_STAGE  2     synchronizer depth, legal >= 2
//  CNT_W       4     pending-count width; max queued events = 2**CNT_W-1
// PORTS
//  clkb        in   1      receive-domain clock
//  clkb_rst_n  in   1      reset, asynchronous assert, active-low; deassert synchronous to clkb
//  t_in        in   1      toggle from the sending domain, asynchronous to clkb
//  p_out       out  1      one-cycle pulse per t_in edge (either polarity)
//  evt_valid   out  1      pending count != 0
//  evt_ready   in   1      consumer accepts one event when evt_valid & evt_ready
//  pend_cnt    out  CNT_W  queued events not yet accepted
//  ovf         out  1      sticky: an event arrived while pend_cnt saturated
//  ovf_clr     in   1      clears ovf (synchronous)
//  ack_t       out  1      SYNC_TGL_RCV_ACK_EN only: toggles once per accepted event
// BEHAVIOUR
//  - Reset: sync chain, edge reference and ack_t = RESET_VAL; p_out=0, pend_cnt=0, evt_valid=0, ovf=0.
//  - Latency: t_in edge meeting setup at clkb edge N -> p_out high for exactly the cycle after edge N+SYNC_STAGE.
//  - Back-to-back t_in edges closer than one clkb period are not resolvable and may merge; the sender
//    guarantees >= SYNC_STAGE+1 clkb periods between toggles (or uses ack_t).
//  - inc = p_out; dec = evt_valid & evt_ready; evt_valid is a registered compare (pend_cnt != 0).
//  - inc & dec same cycle: pend_cnt unchanged, no overflow even when saturated.
//  - inc & !dec at pend_cnt = 2**CNT_W-1: pend_cnt holds, ovf <= 1 (event lost).
//  - dec with pend_cnt = 0 is impossible because evt_valid = 0; evt_ready is ignored when evt_valid = 0.
//  - ovf_clr & overflow same cycle: set wins, ovf stays 1.
//  - Reset mid-operation: all state returns to reset values immediately; queued events are dropped.
//    If t_in != RESET_VAL at release, one event is registered SYNC_STAGE+1 cycles later. The sender
//    domain is reset together with this block.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  SYNC_TGL_RCV_ACK_EN defined:
//    - ack_t port is present.
//    - ack_t <= ~ack_t on every cycle where evt_valid & evt_ready; registered; reset RESET_VAL.
//    - The sender synchronizes ack_t back with its own sync_tgl_rcv/sync_m2d.
//  Undefined: the ack_t port and its flop are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared include sync_defines.vh: EDGE_DET encodings (0 none, 1 pos, 2 neg, 3 any) and the
//    minimum SYNC_STAGE constant; sync_m2d and sync_t2p use the same include.
//  - Sub-module: instance of sync_m2d, EDGE_DET=3, SYNC_STAGE/RESET_VAL passed through, producing p_out.
//  - Pending counter, overflow flag and ack flop live in this module.
// TESTING
//  1 Reset: hold clkb_rst_n=0 with t_in=0 -> after release all outputs 0, no p_out for 10 cycles.
//  2 Latency: SYNC_STAGE=2, toggle t_in 0->1 before edge N -> p_out=1 only in the cycle after
//    edge N+2; pend_cnt=1; evt_valid=1.
//  3 Drain: 3 spaced toggles with evt_ready=0 -> pend_cnt=3. Then evt_ready=1 -> three accepts,
//    pend_cnt 3->2->1->0, evt_valid falls; with ACK_EN, ack_t toggles 3 times and ends at 1.
//  4 Saturation: CNT_W=2, 4 toggles with evt_ready=0 -> pend_cnt=3, ovf=1. Next, ovf_clr coinciding
//    with a 5th event -> ovf stays 1; ovf_clr alone -> ovf=0.
//  5 Simultaneous: pend_cnt=3 (full), evt_ready=1 in the p_out cycle -> pend_cnt stays 3, ovf stays 0.
//  6 Mid-reset: pend_cnt=2, assert clkb_rst_n with t_in=1 -> outputs cleared at once; after release,
//    one p_out at cycle 3 and pend_cnt=1.

Source files
------------

// File: rtl/sync_tgl_rcv_pkg.sv
// ----------------------------------------------------------------------------
// sync_tgl_rcv_pkg
//  Definitions shared by the toggle-event synchronizer family (sync_m2d,
//  sync_t2p, sync_tgl_rcv):
//   - edge_det_e : edge-detect selection (0 none, 1 pos, 2 neg, 3 any)
//   - SYNC_STAGE_MIN : smallest synchronizer depth that is metastability-safe
//   - legal_stages() : clamps a requested depth to the legal range
//   - edge_hit()     : evaluates one edge-detect mode on a cur/prev pair
// ----------------------------------------------------------------------------
package sync_tgl_rcv_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_POS  = 2'd1,
        EDGE_NEG  = 2'd2,
        EDGE_ANY  = 2'd3
    } edge_det_e;

    localparam int SYNC_STAGE_MIN = 2;

    // A shallower chain would defeat the synchronizer, so a too-small request
    // is raised to the minimum rather than silently building an unsafe chain.
    function automatic int legal_stages(input int req);
        int stages_s;
        if (req < SYNC_STAGE_MIN) begin
            stages_s = SYNC_STAGE_MIN;
        end else begin
            stages_s = req;
        end
        return stages_s;
    endfunction

    function automatic logic edge_hit(input edge_det_e mode,
                                      input logic      cur,
                                      input logic      prev);
        logic hit_s;
        case (mode)
            EDGE_NONE: hit_s = 1'b0;
            EDGE_POS:  hit_s = cur & ~prev;
            EDGE_NEG:  hit_s = ~cur & prev;
            EDGE_ANY:  hit_s = cur ^ prev;
            default:   hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

endpackage

// File: rtl/sync_tgl_rcv_m2d.sv
// ----------------------------------------------------------------------------
// sync_m2d
//  Multi-flop synchronizer followed by a registered edge detector. The level
//  d_in is brought into the clk domain through SYNC_STAGE flops; the last
//  stage is compared with an edge-reference flop and a selected edge produces
//  a one-cycle registered pulse.
//
//  Parameters
//   EDGE_DET   edge_det_e  which edge(s) produce a pulse
//   SYNC_STAGE int         synchronizer depth (clamped to >= SYNC_STAGE_MIN)
//   RESET_VAL  logic       reset value of the chain and the edge reference
//
//  Ports
//   clk     in   1   destination clock
//   rst_n   in   1   asynchronous active-low reset
//   d_in    in   1   level from another clock domain
//   p_out   out  1   registered one-cycle pulse per selected edge
// ----------------------------------------------------------------------------
module sync_m2d
    import sync_tgl_rcv_pkg::*;
#(
    parameter edge_det_e EDGE_DET   = EDGE_ANY,
    parameter int        SYNC_STAGE = 2,
    parameter logic      RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic p_out
);

    localparam int STAGES = legal_stages(SYNC_STAGE);

    logic [STAGES-1:0] sync_r;
    logic              edge_ref_r;
    logic              pulse_r;
    logic              hit_s;

    // Synchronizer chain: d_in enters at bit 0, the safe level leaves the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d_in};
        end
    end

    // Edge decision on the synchronized level against the previous level.
    always_comb begin
        hit_s = 1'b0;
        hit_s = edge_hit(EDGE_DET, sync_r[STAGES-1], edge_ref_r);
    end

    // Edge reference and pulse register; the pulse is registered so nothing
    // downstream sees a combinational path from the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_ref_r <= RESET_VAL;
            pulse_r    <= 1'b0;
        end else begin
            edge_ref_r <= sync_r[STAGES-1];
            pulse_r    <= hit_s;
        end
    end

    assign p_out = pulse_r;

endmodule

// File: rtl/sync_tgl_rcv.sv
// ----------------------------------------------------------------------------
// sync_tgl_rcv
//  Receive end of a toggle-encoded event crossing, clocked by clkb. Every edge
//  of the asynchronous toggle t_in becomes one p_out pulse; events are queued
//  in a saturating pending counter drained through evt_valid/evt_ready, and a
//  sticky ovf flag records any event lost while the counter was full.
//
//  Optional feature macro: SYNC_TGL_RCV_ACK_EN
//   defined   -> ack_t port exists and toggles once per accepted event
//   undefined -> no ack_t port or flop
//
//  Parameters
//   RESET_VAL   reset value of sync flops, edge reference and ack_t
//   SYNC_STAGE  synchronizer depth (>= 2)
//   CNT_W       pending-count width; up to 2**CNT_W-1 queued events
//
//  Ports
//   clkb        in   1      receive-domain clock
//   clkb_rst_n  in   1      asynchronous active-low reset
//   t_in        in   1      toggle from the sending domain (asynchronous)
//   p_out       out  1      one-cycle pulse per t_in edge
//   evt_valid   out  1      pend_cnt != 0 (registered)
//   evt_ready   in   1      consumer accepts one event when evt_valid is high
//   pend_cnt    out  CNT_W  queued, not yet accepted events
//   ovf         out  1      sticky overflow flag
//   ovf_clr     in   1      synchronous clear of ovf (an overflow wins)
//   ack_t       out  1      accept toggle (SYNC_TGL_RCV_ACK_EN only)
// ----------------------------------------------------------------------------
module sync_tgl_rcv
    import sync_tgl_rcv_pkg::*;
#(
    parameter logic RESET_VAL  = 1'b0,
    parameter int   SYNC_STAGE = 2,
    parameter int   CNT_W      = 4
) (
    input  logic             clkb,
    input  logic             clkb_rst_n,
    input  logic             t_in,
    output logic             p_out,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    input  logic             ovf_clr
`ifdef SYNC_TGL_RCV_ACK_EN
    ,
    output logic             ack_t
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             pulse_s;
    logic             inc_s;
    logic             dec_s;
    logic             ovf_set_s;
    logic             ovf_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] pend_cnt_r;
    logic             evt_valid_r;
    logic             ovf_r;

    sync_m2d #(
        .EDGE_DET   (EDGE_ANY),
        .SYNC_STAGE (SYNC_STAGE),
        .RESET_VAL  (RESET_VAL)
    ) u_m2d (
        .clk   (clkb),
        .rst_n (clkb_rst_n),
        .d_in  (t_in),
        .p_out (pulse_s)
    );

    // evt_ready only counts while an event is actually offered.
    assign inc_s = pulse_s;
    assign dec_s = evt_valid_r & evt_ready;

    // Pending-count update: a simultaneous arrival and accept cancel out, so a
    // full counter can only overflow on an arrival without an accept.
    always_comb begin
        cnt_nxt_s = pend_cnt_r;
        ovf_set_s = 1'b0;
        if (inc_s && !dec_s) begin
            if (pend_cnt_r == CNT_MAX) begin
                ovf_set_s = 1'b1;
            end else begin
                cnt_nxt_s = pend_cnt_r + CNT_ONE;
            end
        end else if (dec_s && !inc_s) begin
            cnt_nxt_s = pend_cnt_r - CNT_ONE;
        end else begin
            cnt_nxt_s = pend_cnt_r;
        end
    end

    // Sticky overflow: a new loss takes priority over a clear in the same cycle.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Counter, valid and overflow registers. evt_valid is computed from the
    // next count so it always equals (pend_cnt != 0) while staying a flop.
    always_ff @(posedge clkb or negedge clkb_rst_n) begin
        if (!clkb_rst_n) begin
            pend_cnt_r  <= CNT_ZERO;
            evt_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            pend_cnt_r  <= cnt_nxt_s;
            evt_valid_r <= (cnt_nxt_s != CNT_ZERO);
            ovf_r       <= ovf_nxt_s;
        end
    end

`ifdef SYNC_TGL_RCV_ACK_EN
    logic ack_r;

    // Accept acknowledge: one toggle per consumed event for sender throttling.
    always_ff @(posedge clkb or negedge clkb_rst_n) begin
        if (!clkb_rst_n) begin
            ack_r <= RESET_VAL;
        end else if (dec_s) begin
            ack_r <= ~ack_r;
        end else begin
            ack_r <= ack_r;
        end
    end

    assign ack_t = ack_r;
`endif

    assign p_out     = pulse_s;
    assign evt_valid = evt_valid_r;
    assign pend_cnt  = pend_cnt_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_sync_tgl_rcv.sv
// ----------------------------------------------------------------------------
// tb_sync_tgl_rcv
//  Self-checking bench for sync_tgl_rcv (SYNC_STAGE=2, CNT_W=2). A behavioural
//  model tracks events as scheduled pulse times plus an integer pending count;
//  every cycle the DUT outputs are compared with it, and directed scenarios add
//  fixed expected values at the interesting points.
// ----------------------------------------------------------------------------
module tb_sync_tgl_rcv;

    localparam int   SS   = 2;
    localparam int   CW   = 2;
    localparam int   MAXC = (1 << CW) - 1;
    localparam logic RV   = 1'b0;

    logic          clkb;
    logic          clkb_rst_n;
    logic          t_in;
    logic          p_out;
    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] pend_cnt;
    logic          ovf;
    logic          ovf_clr;
`ifdef SYNC_TGL_RCV_ACK_EN
    logic          ack_t;
`endif

    int checks = 0;
    int errors = 0;

    // model state
    int   m_cnt;
    logic m_ovf;
    logic m_p;
    logic m_valid;
    logic m_ack;
    logic m_tprev;
    int   cyc = 0;
    int   due[$];
    int   gap = 0;

    sync_tgl_rcv #(
        .RESET_VAL  (RV),
        .SYNC_STAGE (SS),
        .CNT_W      (CW)
    ) dut (
        .clkb       (clkb),
        .clkb_rst_n (clkb_rst_n),
        .t_in       (t_in),
        .p_out      (p_out),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .pend_cnt   (pend_cnt),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
`ifdef SYNC_TGL_RCV_ACK_EN
        ,
        .ack_t      (ack_t)
`endif
    );

    initial clkb = 1'b0;
    always #5 clkb = ~clkb;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_p     = 1'b0;
        m_valid = 1'b0;
        m_ack   = RV;
        m_tprev = RV;
        due.delete();
    endtask

    // Applies the inputs present at a rising clkb edge to the model.
    task automatic model_edge();
        bit inc;
        bit dec;
        bit lost;
        if (!clkb_rst_n) begin
            model_reset();
        end else begin
            inc  = m_p;
            dec  = m_valid && evt_ready;
            lost = 1'b0;
            if (inc && !dec) begin
                if (m_cnt == MAXC) lost = 1'b1;
                else m_cnt = m_cnt + 1;
            end else if (dec && !inc) begin
                m_cnt = m_cnt - 1;
            end
            if (lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            if (dec) m_ack = ~m_ack;
            // an edge seen at edge N yields a pulse after edge N+SS
            if (t_in != m_tprev) due.push_back(cyc + SS);
            m_tprev = t_in;
            m_p = 1'b0;
            if (due.size() > 0 && due[0] == cyc) begin
                m_p = 1'b1;
                void'(due.pop_front());
            end
            m_valid = (m_cnt != 0);
        end
        cyc++;
    endtask

    task automatic check_all();
        chk("p_out", 32'(p_out), 32'(m_p));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("pend_cnt", 32'(pend_cnt), 32'(m_cnt));
        chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef SYNC_TGL_RCV_ACK_EN
        chk("ack_t", 32'(ack_t), 32'(m_ack));
`endif
    endtask

    // One clock: model follows the rising edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clkb);
        model_edge();
        @(negedge clkb);
        check_all();
    endtask

    task automatic do_reset(input logic t_val);
        t_in       = t_val;
        clkb_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        clkb_rst_n = 1'b1;
        gap = 0;
    endtask

    task automatic toggle_wait(input int n);
        t_in = ~t_in;
        repeat (n) tick();
    endtask

    initial begin
        t_in       = 1'b0;
        evt_ready  = 1'b0;
        ovf_clr    = 1'b0;
        clkb_rst_n = 1'b0;
        model_reset();
        repeat (3) tick();

        // 1: reset release with t_in=0, quiet for 10 cycles
        clkb_rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);

        // 2: latency
        t_in = 1'b1;
        tick();
        chk("lat_n0", 32'(p_out), 32'd0);
        tick();
        chk("lat_n1", 32'(p_out), 32'd0);
        tick();
        chk("lat_n2", 32'(p_out), 32'd1);
        tick();
        chk("lat_after", 32'(p_out), 32'd0);
        chk("lat_pend", 32'(pend_cnt), 32'd1);
        chk("lat_valid", 32'(evt_valid), 32'd1);

        // 3: drain
        do_reset(1'b0);
        repeat (2) tick();
        repeat (3) toggle_wait(5);
        chk("drain_full", 32'(pend_cnt), 32'd3);
        evt_ready = 1'b1;
        tick();
        chk("drain_2", 32'(pend_cnt), 32'd2);
        tick();
        chk("drain_1", 32'(pend_cnt), 32'd1);
        tick();
        chk("drain_0", 32'(pend_cnt), 32'd0);
        chk("drain_valid", 32'(evt_valid), 32'd0);
        evt_ready = 1'b0;
        tick();
`ifdef SYNC_TGL_RCV_ACK_EN
        chk("drain_ack", 32'(ack_t), 32'd1);
`endif

        // 4: saturation and overflow set/clear priority
        do_reset(1'b0);
        repeat (4) toggle_wait(5);
        chk("sat_pend", 32'(pend_cnt), 32'd3);
        chk("sat_ovf", 32'(ovf), 32'd1);
        toggle_wait(3);
        chk("sat_p5", 32'(p_out), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sat_setwins", 32'(ovf), 32'd1);
        chk("sat_hold", 32'(pend_cnt), 32'd3);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("sat_clr", 32'(ovf), 32'd0);

        // 5: arrival and accept in the same cycle while full
        toggle_wait(3);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("sim_pend", 32'(pend_cnt), 32'd3);
        chk("sim_ovf", 32'(ovf), 32'd0);
        tick();

        // 6: reset mid-operation with t_in=1
        do_reset(1'b0);
        repeat (2) toggle_wait(5);
        chk("mid_pend2", 32'(pend_cnt), 32'd2);
        t_in       = 1'b1;
        clkb_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("mid_clr", 32'(pend_cnt), 32'd0);
        repeat (2) tick();
        clkb_rst_n = 1'b1;
        tick();
        tick();
        chk("mid_c2", 32'(p_out), 32'd0);
        tick();
        chk("mid_c3", 32'(p_out), 32'd1);
        tick();
        chk("mid_pend1", 32'(pend_cnt), 32'd1);

        // randomized traffic against the model
        gap = 0;
        for (int i = 0; i < 500; i++) begin
            evt_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            if (gap >= SS + 1 && $urandom_range(0, 2) != 0) begin
                t_in = ~t_in;
                gap  = 0;
            end
            if ($urandom_range(0, 149) == 0) begin
                do_reset(t_in);
            end else begin
                tick();
                gap++;
            end
        end
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
